// File: rtl/risc_ctrl_pkg.sv
// Control-word layout, ISA encodings and the combinational decoder used
// by the decode stage.
package risc_ctrl_pkg;

  // Field widths
  localparam int REG_DST_W  = 2;
  localparam int ALU_IMM_W  = 2;
  localparam int LOGIC_FN_W = 3;
  localparam int FN_CLASS_W = 2;
  localparam int REGIN_W    = 2;
  localparam int BR_TYPE_W  = 4;
  localparam int PC_SEL_W   = 2;
  localparam int CTRL_W     = 21;

  // Field offsets (LSB of each field within the 21-bit word)
  localparam int PC_SEL_LSB     = 0;
  localparam int BR_TYPE_LSB    = 2;
  localparam int REGIN_LSB      = 6;
  localparam int DATA_WRITE_BIT = 8;
  localparam int DATA_READ_BIT  = 9;
  localparam int FN_CLASS_LSB   = 10;
  localparam int LOGIC_FN_LSB   = 12;
  localparam int FN_BIT         = 15;
  localparam int ALU_IMM_LSB    = 16;
  localparam int REG_WRITE_BIT  = 18;
  localparam int REG_DST_LSB    = 19;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_BLTZ   = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_BLEZ   = 6'h10;
  localparam logic [5:0] OP_BGTZ   = 6'h11;
  localparam logic [5:0] OP_BGEZ   = 6'h12;
  localparam logic [5:0] OP_BLTZAL = 6'h13;
  localparam logic [5:0] OP_BGEZAL = 6'h14;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_SLLV = 6'd29;
  localparam logic [5:0] FN_SRLV = 6'd30;
  localparam logic [5:0] FN_SRAV = 6'd31;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_ROTV = 6'd40;
  localparam logic [5:0] FN_SLT  = 6'd42;

  // Destination register select
  localparam logic [1:0] RD_RD  = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // Second ALU operand source
  localparam logic [1:0] IMM_REG   = 2'b00;
  localparam logic [1:0] IMM_SEXT  = 2'b01;
  localparam logic [1:0] IMM_ZEXT  = 2'b10;
  localparam logic [1:0] IMM_UPPER = 2'b11;

  // ALU result class
  localparam logic [1:0] CLS_LUI   = 2'b00;
  localparam logic [1:0] CLS_SLT   = 2'b01;
  localparam logic [1:0] CLS_ARITH = 2'b10;
  localparam logic [1:0] CLS_LOGIC = 2'b11;

  // Logic-unit op; the upper half of the code space drives the shifter
  localparam logic [2:0] LF_AND  = 3'd0;
  localparam logic [2:0] LF_OR   = 3'd1;
  localparam logic [2:0] LF_XOR  = 3'd2;
  localparam logic [2:0] LF_NOR  = 3'd3;
  localparam logic [2:0] LF_SLL  = 3'd4;
  localparam logic [2:0] LF_SRL  = 3'd5;
  localparam logic [2:0] LF_SRA  = 3'd6;
  localparam logic [2:0] LF_ROT  = 3'd7;

  // Register write-back source
  localparam logic [1:0] REGIN_MEM  = 2'b00;
  localparam logic [1:0] REGIN_ALU  = 2'b01;
  localparam logic [1:0] REGIN_LINK = 2'b10;

  typedef enum logic [BR_TYPE_W-1:0] {
    BR_NONE = 4'd0, BR_EQ  = 4'd1, BR_NE  = 4'd2, BR_LTZ   = 4'd3,
    BR_LEZ  = 4'd4, BR_GTZ = 4'd5, BR_GEZ = 4'd6, BR_LTZAL = 4'd7,
    BR_GEZAL = 4'd8
  } br_type_e;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEQ = 2'b00, PC_JUMP = 2'b01, PC_REG = 2'b10
  } pc_sel_e;

  typedef struct packed {
    logic [REG_DST_W-1:0]  reg_dst;
    logic                  reg_write;
    logic [ALU_IMM_W-1:0]  alu_imm;
    logic                  fn;
    logic [LOGIC_FN_W-1:0] logic_fn;
    logic [FN_CLASS_W-1:0] fn_class;
    logic                  data_read;
    logic                  data_write;
    logic [REGIN_W-1:0]    regin_data;
    br_type_e              br_type;
    pc_sel_e               pc_sel;
  } ctrl_t;

  // Returns {ctrl, illegal}; every unused field stays 0 and an undefined
  // encoding yields an all-zero control word.
  function automatic logic [CTRL_W:0] decode(input logic [5:0] opcode,
                                             input logic [5:0] funct);
    ctrl_t c;
    logic  ill;
    c   = '0;
    ill = 1'b0;
    if (opcode == OP_RTYPE) begin
      c.reg_dst    = RD_RD;
      c.reg_write  = 1'b1;
      c.regin_data = REGIN_ALU;
      case (funct)
        FN_ADD:  c.fn_class = CLS_ARITH;
        FN_SUB:  begin c.fn = 1'b1; c.fn_class = CLS_ARITH; end
        FN_SLT:  begin c.fn = 1'b1; c.fn_class = CLS_SLT;   end
        FN_AND:  begin c.logic_fn = LF_AND; c.fn_class = CLS_LOGIC; end
        FN_OR:   begin c.logic_fn = LF_OR;  c.fn_class = CLS_LOGIC; end
        FN_XOR:  begin c.logic_fn = LF_XOR; c.fn_class = CLS_LOGIC; end
        FN_NOR:  begin c.logic_fn = LF_NOR; c.fn_class = CLS_LOGIC; end
        FN_SLLV: begin c.logic_fn = LF_SLL; c.fn_class = CLS_LOGIC; end
        FN_SRLV: begin c.logic_fn = LF_SRL; c.fn_class = CLS_LOGIC; end
        FN_SRAV: begin c.logic_fn = LF_SRA; c.fn_class = CLS_LOGIC; end
        FN_ROTV: begin c.logic_fn = LF_ROT; c.fn_class = CLS_LOGIC; end
        FN_JR: begin
          c.reg_write  = 1'b0;
          c.regin_data = REGIN_MEM;
          c.pc_sel     = PC_REG;
        end
        default: ill = 1'b1;
      endcase
    end else begin
      case (opcode)
        OP_ANDI, OP_ORI: begin
          c.reg_dst    = RD_RT;
          c.reg_write  = 1'b1;
          c.alu_imm    = IMM_ZEXT;
          c.logic_fn   = (opcode == OP_ORI) ? LF_OR : LF_AND;
          c.fn_class   = CLS_LOGIC;
          c.regin_data = REGIN_ALU;
        end
        OP_LUI: begin
          c.reg_dst    = RD_RT;
          c.reg_write  = 1'b1;
          c.alu_imm    = IMM_UPPER;
          c.fn_class   = CLS_LUI;
          c.regin_data = REGIN_ALU;
        end
        OP_LW: begin
          c.reg_dst    = RD_RT;
          c.reg_write  = 1'b1;
          c.alu_imm    = IMM_SEXT;
          c.fn_class   = CLS_ARITH;
          c.data_read  = 1'b1;
          c.regin_data = REGIN_MEM;
        end
        OP_SW: begin
          c.alu_imm    = IMM_SEXT;
          c.fn_class   = CLS_ARITH;
          c.data_write = 1'b1;
        end
        OP_J:  c.pc_sel = PC_JUMP;
        OP_JAL: begin
          c.reg_dst    = RD_R31;
          c.reg_write  = 1'b1;
          c.regin_data = REGIN_LINK;
          c.pc_sel     = PC_JUMP;
        end
        OP_BEQ:  begin c.fn = 1'b1; c.fn_class = CLS_ARITH; c.br_type = BR_EQ; end
        OP_BNE:  begin c.fn = 1'b1; c.fn_class = CLS_ARITH; c.br_type = BR_NE; end
        OP_BLTZ: c.br_type = BR_LTZ;
        OP_BLEZ: c.br_type = BR_LEZ;
        OP_BGTZ: c.br_type = BR_GTZ;
        OP_BGEZ: c.br_type = BR_GEZ;
        OP_BLTZAL, OP_BGEZAL: begin
          c.reg_dst    = RD_R31;
          c.reg_write  = 1'b1;
          c.regin_data = REGIN_LINK;
          c.br_type    = (opcode == OP_BLTZAL) ? BR_LTZAL : BR_GEZAL;
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) c = '0;
    return {c, ill};
  endfunction

endpackage

// File: rtl/ctrl_fifo.sv
// Circular buffer of decoded entries with synchronous flush.
module ctrl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    push_ok, pop_ok;

  // Guard against popping empty or overfilling, independent of the caller
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || pop_ok);

  // Pointer and occupancy update; flush wins over any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Entry storage; contents are only observed through a non-zero count
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode stage: combinational ISA decode into a 1-cycle-latency buffer of
// {ctrl, illegal, link} entries, with flush and an illegal-op counter.
module ctrl_decode_stage
  import risc_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        function_val,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [PC_W-1:0]   link_out,
  output logic              illegal_out,
  output logic [7:0]        illegal_cnt
);

  localparam int EW = CTRL_W + 1 + PC_W;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CTRL_W:0]   dec;
  logic [CTRL_W-1:0] dec_ctrl, head_ctrl;
  logic              dec_ill, head_ill;
  logic [PC_W-1:0]   dec_link, head_link;
  logic [EW-1:0]     fifo_rdata;
  logic [CW-1:0]     count;
  logic              ready_en, push, pop, full;

  assign dec                 = decode(opcode, function_val);
  assign {dec_ctrl, dec_ill} = dec;
  assign dec_link            = pc_in + PC_W'(4);

  // Holds in_ready low until the first edge after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = ready_en && !flush && (!full || pop);
  assign push      = in_valid && in_ready;

  ctrl_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({dec_ctrl, dec_ill, dec_link}),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign {head_ctrl, head_ill, head_link} = fifo_rdata;

  // Head outputs are zeroed whenever nothing is buffered
  assign ctrl_out    = out_valid ? head_ctrl : '0;
  assign link_out    = out_valid ? head_link : '0;
  assign illegal_out = out_valid && head_ill;

  // Saturating count of accepted illegal encodings; flush does not touch it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     illegal_cnt <= '0;
    else if (push && dec_ill && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage (PC_W=32, DEPTH=2).
// Expected control words, bit layout [20:19]reg_dst [18]reg_write
// [17:16]alu_imm [15]fn [14:12]logic_fn [11:10]fn_class [9]data_read
// [8]data_write [7:6]regin_data [5:2]br_type [1:0]pc_sel:
//   lw  0xD0A00  sw 0x10900  jal 0x140081  j 0x1
//   add 0x40840  sub 0x48840 beq 0x8804   jr 0x2  ori 0xE1C40
module tb_ctrl_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, illegal_out;
  logic [5:0]  opcode, function_val;
  logic [31:0] pc_in, link_out;
  logic [20:0] ctrl_out;
  logic [7:0]  illegal_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  ctrl_decode_stage #(.PC_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .function_val(function_val), .pc_in(pc_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .link_out(link_out), .illegal_out(illegal_out), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc);
    in_valid = 1'b1; opcode = op; function_val = fn; pc_in = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; function_val = '0; pc_in = '0;
    flush = 1'b0; out_ready = 1'b0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (ctrl_out !== 21'h0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", ctrl_out); end
    n_cmp++; if (link_out !== 32'h0) begin n_bad++; $display("FAIL rst_link: got %h want 0", link_out); end
    n_cmp++; if (illegal_out !== 1'b0) begin n_bad++; $display("FAIL rst_illegal: got %b want 0", illegal_out); end
    n_cmp++; if (illegal_cnt !== 8'h0) begin n_bad++; $display("FAIL rst_illegal_cnt: got %0d want 0", illegal_cnt); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_first_edge_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_lw();
    present(6'h23, 6'h0, 32'h100); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lw_in_ready: got %b want 1", in_ready); end
    tick(); in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lw_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (ctrl_out !== 21'hD0A00) begin n_bad++; $display("FAIL lw_ctrl: got %h want d0a00", ctrl_out); end
    n_cmp++; if (link_out !== 32'h104) begin n_bad++; $display("FAIL lw_link: got %h want 104", link_out); end
    n_cmp++; if (illegal_out !== 1'b0) begin n_bad++; $display("FAIL lw_illegal: got %b want 0", illegal_out); end
    out_ready = 1'b1; tick(); out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lw_drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (ctrl_out !== 21'h0 || link_out !== 32'h0) begin n_bad++; $display("FAIL lw_drain_zero: got %h/%h want 0/0", ctrl_out, link_out); end
  endtask

  task automatic test_jal_wrap();
    present(6'h03, 6'h0, 32'hFFFF_FFFC); tick(); in_valid = 1'b0; #1;
    n_cmp++; if (ctrl_out !== 21'h140081) begin n_bad++; $display("FAIL jal_ctrl: got %h want 140081", ctrl_out); end
    n_cmp++; if (link_out !== 32'h0) begin n_bad++; $display("FAIL jal_link_wrap: got %h want 0", link_out); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // Streams push+pop every cycle; head is checked one cycle after each push
  task automatic test_back_to_back();
    logic [5:0]  ops [6];
    logic [5:0]  fns [6];
    logic [20:0] exp_c [6];
    ops   = '{6'h00, 6'h00, 6'h04, 6'h00, 6'h0D, 6'h2B};
    fns   = '{6'd32, 6'd34, 6'd0, 6'd8, 6'd0, 6'd0};
    exp_c = '{21'h40840, 21'h48840, 21'h08804, 21'h00002, 21'hE1C40, 21'h10900};
    out_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) present(ops[i], fns[i], 32'h1000 + 32'(i * 4));
      else in_valid = 1'b0;
      #1;
      if (i > 0) begin
        n_cmp++;
        if (ctrl_out !== exp_c[i-1] || link_out !== 32'h1000 + 32'(i * 4))
          begin n_bad++; $display("FAIL b2b_entry%0d: got %h/%h want %h/%h", i-1, ctrl_out, link_out, exp_c[i-1], 32'h1000 + 32'(i * 4)); end
      end
      tick();
    end
    out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    present(6'h23, 6'h0, 32'h200); tick();
    present(6'h2B, 6'h0, 32'h300); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_one_ready: got %b want 1", in_ready); end
    tick(); in_valid = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_low: got %b want 0", in_ready); end
    n_cmp++; if (link_out !== 32'h204) begin n_bad++; $display("FAIL full_head: got %h want 204", link_out); end
    present(6'h02, 6'h0, 32'h400); out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_pushpop_ready: got %b want 1", in_ready); end
    tick(); in_valid = 1'b0; out_ready = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_still_full: got %b want 0", in_ready); end
    n_cmp++; if (ctrl_out !== 21'h10900 || link_out !== 32'h304) begin n_bad++; $display("FAIL full_order_b: got %h/%h want 10900/304", ctrl_out, link_out); end
    tick();
    n_cmp++; if (link_out !== 32'h304) begin n_bad++; $display("FAIL full_hold: got %h want 304", link_out); end
    out_ready = 1'b1; tick();
    n_cmp++; if (ctrl_out !== 21'h00001 || link_out !== 32'h404) begin n_bad++; $display("FAIL full_order_c: got %h/%h want 00001/404", ctrl_out, link_out); end
    tick(); out_ready = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    present(6'h3F, 6'h0, 32'h600); tick(); in_valid = 1'b0; #1;
    n_cmp++; if (illegal_out !== 1'b1 || ctrl_out !== 21'h0) begin n_bad++; $display("FAIL ill_op3f: got ill=%b ctrl=%h want 1/0", illegal_out, ctrl_out); end
    n_cmp++; if (link_out !== 32'h604) begin n_bad++; $display("FAIL ill_link: got %h want 604", link_out); end
    n_cmp++; if (illegal_cnt !== 8'd1) begin n_bad++; $display("FAIL ill_cnt1: got %0d want 1", illegal_cnt); end
    present(6'h00, 6'h01, 32'h700); out_ready = 1'b1; tick(); in_valid = 1'b0; out_ready = 1'b0; #1;
    n_cmp++; if (illegal_out !== 1'b1 || ctrl_out !== 21'h0) begin n_bad++; $display("FAIL ill_fn01: got ill=%b ctrl=%h want 1/0", illegal_out, ctrl_out); end
    n_cmp++; if (illegal_cnt !== 8'd2) begin n_bad++; $display("FAIL ill_cnt2: got %0d want 2", illegal_cnt); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    present(6'h00, 6'd32, 32'h700); tick();
    present(6'h0D, 6'h0, 32'h704); tick(); in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_prefull: got v=%b r=%b want 1/0", out_valid, in_ready); end
    flush = 1'b1; present(6'h3F, 6'h0, 32'h900); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || ctrl_out !== 21'h0) begin n_bad++; $display("FAIL flush_empty: got v=%b ctrl=%h want 0/0", out_valid, ctrl_out); end
    n_cmp++; if (illegal_cnt !== 8'd2) begin n_bad++; $display("FAIL flush_cnt: got %0d want 2", illegal_cnt); end
    // Flush with room in the buffer: the concurrent push must still be dropped
    present(6'h23, 6'h0, 32'h500); tick();
    flush = 1'b1; present(6'h3F, 6'h0, 32'h904); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_room_ready: got %b want 0", in_ready); end
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || illegal_cnt !== 8'd2) begin n_bad++; $display("FAIL flush_room_drop: got v=%b cnt=%0d want 0/2", out_valid, illegal_cnt); end
    present(6'h23, 6'h0, 32'h500); tick(); in_valid = 1'b0; #1;
    n_cmp++; if (ctrl_out !== 21'hD0A00 || link_out !== 32'h504) begin n_bad++; $display("FAIL flush_after: got %h/%h want d0a00/504", ctrl_out, link_out); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    present(6'h3F, 6'h0, 32'h0);
    for (int i = 0; i < 100; i++) tick();
    in_valid = 1'b0; tick();
    n_cmp++; if (illegal_cnt !== 8'd102) begin n_bad++; $display("FAIL sat_mid: got %0d want 102", illegal_cnt); end
    present(6'h3F, 6'h0, 32'h0);
    for (int i = 0; i < 200; i++) tick();
    in_valid = 1'b0; tick(); out_ready = 1'b0; #1;
    n_cmp++; if (illegal_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_max: got %0d want 255", illegal_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    present(6'h00, 6'd32, 32'h800); tick();
    present(6'h03, 6'h0, 32'h804); tick(); in_valid = 1'b0; #1;
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_full: got r=%b v=%b want 0/1", in_ready, out_valid); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_hs: got v=%b r=%b want 0/0", out_valid, in_ready); end
    n_cmp++; if (ctrl_out !== 21'h0 || link_out !== 32'h0 || illegal_out !== 1'b0) begin n_bad++; $display("FAIL rmid_data: got %h/%h/%b want 0/0/0", ctrl_out, link_out, illegal_out); end
    n_cmp++; if (illegal_cnt !== 8'd0) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 0", illegal_cnt); end
    #2; rst_n = 1'b1; tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", in_ready); end
    present(6'h03, 6'h0, 32'h10); tick(); in_valid = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b1 || ctrl_out !== 21'h140081 || link_out !== 32'h14) begin n_bad++; $display("FAIL rmid_first: got v=%b %h/%h want 1 140081/14", out_valid, ctrl_out, link_out); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_jal_wrap();
    test_back_to_back();
    test_full();
    test_illegal();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 Parameter PC_W, default 32, program-counter width in bits, legal range 8..32.
REQ-002 Parameter DEPTH, default 2, decoded-entry buffer depth, power of two, at least 2.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: the sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: an instruction is presented.
REQ-007 Port in_ready, output, 1 bit: the stage accepts an instruction this cycle.
REQ-008 Port opcode, input, 6 bits: instruction opcode field.
REQ-009 Port function_val, input, 6 bits: R-type function field.
REQ-010 Port pc_in, input, PC_W bits: address of the presented instruction.
REQ-011 Port flush, input, 1 bit: discard all buffered entries.
REQ-012 Port out_valid, output, 1 bit: the head entry is valid.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the head entry.
REQ-014 Port ctrl_out, output, 21 bits: control word in field order reg_dst[2], reg_write, alu_imm[2], fn, logic_fn[3], fn_class, data_read, data_write, regin_data[2], br_type[4], pc_sel[2], MSB first.
REQ-015 Port link_out, output, PC_W bits: pc_in+4 of the head entry.
REQ-016 Port illegal_out, output, 1 bit: the head entry's encoding is undefined.
REQ-017 Port illegal_cnt, output, 8 bits: count of accepted illegal instructions.

Function
REQ-018 Decoding shall be combinational from opcode/function_val using the ISA control table.
  - Opcode 0 selects the function table: 32, 34, 42, 36, 31, 30, 37, 38, 29, 39, 40, 8.
  - Otherwise the opcode table applies: 0x0C, 0x0D, 0x23, 0x2B, 0x02, 0x03, 0x01, 0x04, 0x05, 0x0F, 0x10..0x14.
REQ-019 Every table don't-care field shall decode to 0; no output shall carry X and no latch shall be inferred.
REQ-020 An undefined opcode or function shall decode to an all-zero control word with illegal=1.
REQ-021 A handshake shall occur when in_valid&&in_ready; the decoded word, the illegal bit and link=pc_in+4 (mod 2^PC_W) are written to the buffer tail.
REQ-022 in_ready shall equal (count<DEPTH)||(out_valid&&out_ready), registered-count based.
REQ-023 The buffer shall be a circular FIFO: read/write pointers wrap at DEPTH; count ranges 0..DEPTH.
REQ-024 Latency shall be 1 cycle: an entry accepted in cycle N is visible at the outputs in cycle N+1.
REQ-025 out_valid shall equal count!=0; ctrl_out, link_out and illegal_out shall be 0 when out_valid=0.
REQ-026 Simultaneous push and pop shall leave count unchanged, including when the buffer is full.
REQ-027 While out_valid&&!out_ready, the head entry shall be held stable.
REQ-028 flush shall clear count and both pointers next cycle; in_ready shall be 0 during flush; an instruction presented in a flush cycle is dropped.
REQ-029 illegal_cnt shall increment on each accepted illegal instruction, saturate at 255, and be unaffected by flush.

Reset
REQ-030 rst_n low shall immediately force count=0, pointers=0, out_valid=0, in_ready=0, ctrl_out=0, link_out=0, illegal_out=0, illegal_cnt=0.
REQ-031 in_ready shall rise on the first clock edge after rst_n deasserts; reset mid-transfer discards all entries.

Structure
REQ-032 Package risc_ctrl_pkg shall hold the control-word field widths and offsets, the opcode and function constants, and the br_type/pc_sel encodings.
REQ-033 The package shall also hold the decode function returning {ctrl, illegal}.
REQ-034 Buffering shall be one sub-module, ctrl_fifo, parametrised by width and DEPTH; decoding stays in ctrl_decode_stage.

Verification
REQ-035 Test 1: reset, then push opcode 0x23, pc_in 0x100 -> next cycle out_valid=1, ctrl_out reg_dst=01, reg_write=1, alu_imm=01, data_read=1, regin_data=00, link_out=0x104.
REQ-036 Test 2: push opcode 0x03 (jal), pc_in 0xFFFFFFFC, PC_W=32 -> reg_dst=10, regin_data=10, pc_sel=01, link_out=0x0.
REQ-037 Test 3: hold out_ready=0 and push DEPTH entries -> in_ready=0 on the full buffer; then push and pop in the same cycle -> count stays DEPTH and the entries exit in FIFO order.
REQ-038 Test 4: push opcode 0x3F, then opcode 0 with function 0x01 -> illegal_out=1 with ctrl_out=0 for both; illegal_cnt=2; after 300 illegal pushes illegal_cnt=255.
REQ-039 Test 5: with 2 entries buffered, assert flush -> out_valid=0 next cycle; a push concurrent with flush is lost; illegal_cnt is unchanged.
REQ-040 Test 6: drop rst_n mid-stream with the buffer full -> all outputs are 0 asynchronously; the first post-reset push is at the head after 1 cycle.
